// File: rtl/clint_arb_pkg.sv
// Shared sizing, FSM states, pending-slot layout and slot builder for the CLINT arbiter.
// CORE_NUMS mirrors the value configured in aquila_config.vh.
package clint_arb_pkg;

  localparam int XLEN      = 32;
  localparam int CORE_NUMS = 4;
  localparam int IDX_W     = (CORE_NUMS > 1) ? $clog2(CORE_NUMS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } clint_arb_state_e;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } clint_arb_slot_t;

  function automatic clint_arb_slot_t make_slot(input logic            we,
                                                input logic [XLEN-1:0] addr,
                                                input logic [XLEN-1:0] data);
    clint_arb_slot_t s;
    s.valid = 1'b1;
    s.we    = we;
    s.addr  = addr;
    s.data  = data;
    return s;
  endfunction

endpackage

// File: rtl/clint_arb_picker.sv
// Combinational picker: rotate the valid vector to start at start_i, take the
// lowest set bit, and map the offset back to an absolute core index.
module clint_arb_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] grant_o,
  output logic         any_valid_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  logic         found;

  always_comb begin
    rot   = N'({valid_i, valid_i} >> start_i);
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = W'(k);
      end
    end
    // Wrap start + offset back into 0..N-1 without a divider.
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    grant_o     = sum[W-1:0];
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/clint_arbiter.sv
// Serialises single-cycle requests from CORE_NUMS cores onto the one CLINT port.
// Macro CLINT_ARB_RR_EN selects round-robin; left undefined, lowest index wins.
module clint_arbiter
  import clint_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_en_i    [0:CORE_NUMS-1],
  input  logic             core_we_i    [0:CORE_NUMS-1],
  input  logic [XLEN-1:0]  core_addr_i  [0:CORE_NUMS-1],
  input  logic [XLEN-1:0]  core_data_i  [0:CORE_NUMS-1],
  output logic [XLEN-1:0]  core_data_o  [0:CORE_NUMS-1],
  output logic             core_ready_o [0:CORE_NUMS-1],
  output logic             clint_en_o,
  output logic             clint_we_o,
  output logic [XLEN-1:0]  clint_addr_o,
  output logic [XLEN-1:0]  clint_data_o,
  input  logic [XLEN-1:0]  clint_data_i,
  input  logic             clint_ready_i,
  output clint_arb_state_e state_o
);

  // Handshake: a core presents one request with a one-cycle core_en_i pulse and
  // must not pulse again until its one-cycle core_ready_o; the CLINT sees a
  // one-cycle clint_en_o and answers with a one-cycle clint_ready_i.

  clint_arb_state_e     state_q, state_d;
  clint_arb_slot_t      slot_q [CORE_NUMS];
  logic [CORE_NUMS-1:0] valid_vec;
  logic [IDX_W-1:0]     grant_q, pick_idx, start_idx;
  logic                 any_valid, grant_now, done;

  assign state_o = state_q;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < CORE_NUMS; i++) begin
      valid_vec[i] = slot_q[i].valid;
    end
  end

  clint_arb_picker #(
    .N(CORE_NUMS),
    .W(IDX_W)
  ) u_picker (
    .valid_i    (valid_vec),
    .start_i    (start_idx),
    .grant_o    (pick_idx),
    .any_valid_o(any_valid)
  );

`ifdef CLINT_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (done) begin
      ptr_q <= (grant_q == IDX_W'(CORE_NUMS - 1)) ? '0 : grant_q + IDX_W'(1);
    end
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_now = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d   = S_ISSUE;
          grant_now = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (clint_ready_i) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CLINT-side fields are loaded on the grant so they appear together with clint_en_o
  // and then simply hold until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      clint_en_o   <= 1'b0;
      clint_we_o   <= 1'b0;
      clint_addr_o <= '0;
      clint_data_o <= '0;
    end else begin
      state_q    <= state_d;
      clint_en_o <= grant_now;
      if (grant_now) begin
        grant_q      <= pick_idx;
        clint_we_o   <= slot_q[pick_idx].we;
        clint_addr_o <= slot_q[pick_idx].addr;
        clint_data_o <= slot_q[pick_idx].data;
      end
    end
  end

  // A pulse arriving while the granted slot is being retired refills it;
  // a pulse into an occupied slot is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CORE_NUMS; i++) begin
        slot_q[i]       <= '0;
        core_data_o[i]  <= '0;
        core_ready_o[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CORE_NUMS; i++) begin
        core_ready_o[i] <= done && (grant_q == IDX_W'(i));
        if (done && (grant_q == IDX_W'(i))) begin
          if (!slot_q[i].we) begin
            core_data_o[i] <= clint_data_i;
          end
          if (core_en_i[i]) begin
            slot_q[i] <= make_slot(core_we_i[i], core_addr_i[i], core_data_i[i]);
          end else begin
            slot_q[i] <= '0;
          end
        end else if (core_en_i[i] && !slot_q[i].valid) begin
          slot_q[i] <= make_slot(core_we_i[i], core_addr_i[i], core_data_i[i]);
        end
      end
    end
  end

endmodule
